// File: rtl/main_mem_burst_emul.sv
// Main-memory burst emulator for the pixel-pipeline cache fill path.
// Accepts one burst read request, waits LAT cycles, then streams BURST_LEN
// address/data beats under valid/ready and pulses done once the last beat
// has been taken.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; base/idx/latency loaded on acceptance
// S_WAIT  | access latency countdown, exactly LAT cycles
// S_BURST | wr_valid high, one beat per accept, holds while stalled
// S_DONE  | single-cycle done pulse, then back to S_IDLE
module main_mem_burst_emul #(
   parameter int               ADDR_W    = 19,
   parameter int               DATA_W    = 32,
   parameter int               BURST_LEN = 512,
   parameter int               LAT       = 4,
   parameter bit               WRAP      = 1'b0,
   parameter logic [DATA_W-1:0] SEED     = 32'hA5A5_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_last,
   input  logic              wr_ready,
   output logic              done,
   output logic              busy
);

   localparam int               IDX_W    = $clog2(BURST_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);
   localparam logic [7:0]       LAT_V    = 8'(LAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [IDX_W-1:0]  r_idx;
   logic [7:0]        r_lat_cnt;
   logic              r_req_ready;
   logic              r_busy;
   logic              r_wr_valid;
   logic              r_wr_last;
   logic              r_done;

   logic [ADDR_W-1:0] w_mask;
   logic [ADDR_W-1:0] w_sum;
   logic [ADDR_W-1:0] w_beat_addr;

   // Beat address is a pure function of the latched base and beat index;
   // wrap mode keeps the bits above the burst window and rolls the low bits.
   always_comb begin
      w_mask = ADDR_W'(BURST_LEN - 1);
      w_sum  = r_base + ADDR_W'(r_idx);
      if (WRAP)
         w_beat_addr = (r_base & ~w_mask) | (w_sum & w_mask);
      else
         w_beat_addr = w_sum;
   end

   // Burst sequencer: state, counters and all handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_idx       <= '0;
         r_lat_cnt   <= '0;
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_wr_valid  <= 1'b0;
         r_wr_last   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_base      <= req_addr;
                  r_idx       <= '0;
                  r_lat_cnt   <= LAT_V;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (LAT > 0) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_state    <= S_BURST;
                     r_wr_valid <= 1'b1;
                     r_wr_last  <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               r_lat_cnt <= r_lat_cnt - 8'd1;
               if (r_lat_cnt == 8'd1) begin
                  r_state    <= S_BURST;
                  r_wr_valid <= 1'b1;
                  r_wr_last  <= 1'b0;
               end
            end
            S_BURST: begin
               if (wr_ready) begin
                  if (r_idx == IDX_LAST) begin
                     r_state    <= S_DONE;
                     r_wr_valid <= 1'b0;
                     r_wr_last  <= 1'b0;
                     r_done     <= 1'b1;
                  end else begin
                     r_idx     <= r_idx + IDX_W'(1);
                     r_wr_last <= ((r_idx + IDX_W'(1)) == IDX_LAST);
                  end
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_done      <= 1'b0;
               r_busy      <= 1'b0;
               r_req_ready <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_wr_valid  <= 1'b0;
               r_wr_last   <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign busy      = r_busy;
   assign wr_valid  = r_wr_valid;
   assign wr_last   = r_wr_last;
   assign done      = r_done;
   assign wr_addr   = w_beat_addr;
   assign wr_data   = SEED ^ DATA_W'(w_beat_addr);

endmodule

// File: tb/tb_main_mem_burst_emul.sv
// Directed bench for main_mem_burst_emul: three instances cover
// incrementing (LAT=2, 8 beats), wrapping (LAT=2, 8 beats) and
// rollover with zero latency (LAT=0, 4 beats).
module tb_main_mem_burst_emul;

   localparam logic [31:0] SEED = 32'hA5A5_0000;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [18:0] req_addr [3];
   logic [2:0]  req_ready;
   logic [2:0]  wr_valid;
   logic [18:0] wr_addr [3];
   logic [31:0] wr_data [3];
   logic [2:0]  wr_last;
   logic [2:0]  wr_ready;
   logic [2:0]  done;
   logic [2:0]  busy;

   int n_total = 0;
   int n_bad   = 0;

   logic [18:0] ea_basic [8] = '{19'h10, 19'h11, 19'h12, 19'h13, 19'h14, 19'h15, 19'h16, 19'h17};
   logic [18:0] ea_wrap  [8] = '{19'h1D, 19'h1E, 19'h1F, 19'h18, 19'h19, 19'h1A, 19'h1B, 19'h1C};
   logic [18:0] ea_roll  [8] = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001, 19'h0, 19'h0, 19'h0, 19'h0};
   logic [18:0] ea_40    [8] = '{19'h40, 19'h41, 19'h42, 19'h43, 19'h44, 19'h45, 19'h46, 19'h47};
   logic [18:0] ea_60    [8] = '{19'h60, 19'h61, 19'h62, 19'h63, 19'h64, 19'h65, 19'h66, 19'h67};
   logic [18:0] ea_30    [8] = '{19'h30, 19'h31, 19'h32, 19'h33, 19'h34, 19'h35, 19'h36, 19'h37};

   main_mem_burst_emul #(.ADDR_W(19), .DATA_W(32), .BURST_LEN(8), .LAT(2), .WRAP(1'b0), .SEED(SEED)) u_inc (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
      .wr_valid(wr_valid[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_last(wr_last[0]),
      .wr_ready(wr_ready[0]), .done(done[0]), .busy(busy[0]));

   main_mem_burst_emul #(.ADDR_W(19), .DATA_W(32), .BURST_LEN(8), .LAT(2), .WRAP(1'b1), .SEED(SEED)) u_wrap (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
      .wr_valid(wr_valid[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_last(wr_last[1]),
      .wr_ready(wr_ready[1]), .done(done[1]), .busy(busy[1]));

   main_mem_burst_emul #(.ADDR_W(19), .DATA_W(32), .BURST_LEN(4), .LAT(0), .WRAP(1'b0), .SEED(SEED)) u_roll (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_addr(req_addr[2]), .req_ready(req_ready[2]),
      .wr_valid(wr_valid[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .wr_last(wr_last[2]),
      .wr_ready(wr_ready[2]), .done(done[2]), .busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raise a request and wait for its acceptance edge; returns sampled just after it.
   task automatic accept(input int d, input logic [18:0] a);
      int cyc;
      req_addr[d]  = a;
      req_valid[d] = 1'b1;
      cyc = 0;
      while (!req_ready[d] && cyc < 100) begin
         step();
         cyc++;
      end
      chk("acc_wait_ready", req_ready[d], 1'b1);
      step();
      req_valid[d] = 1'b0;
      chk("acc_busy", busy[d], 1'b1);
      chk("acc_req_ready", req_ready[d], 1'b0);
   endtask

   // Follow one burst from just after acceptance through to the DONE cycle.
   task automatic stream(input int d, input int lat, input int n, input logic [18:0] ea [8],
                         input logic [3:0] pat, input int inj);
      int  cyc;
      int  beat;
      int  pc;
      int  guard;
      bit  rdy;
      bit  pulsed;
      cyc = 0;
      while (!wr_valid[d] && cyc < 300) begin
         chk("wait_busy", busy[d], 1'b1);
         step();
         cyc++;
      end
      chk("first_valid_lat", cyc, lat);
      beat  = 0;
      pc    = 0;
      guard = 0;
      while (beat < n && guard < 200) begin
         guard++;
         chk("beat_valid", wr_valid[d], 1'b1);
         chk("beat_addr", wr_addr[d], ea[beat]);
         chk("beat_data", wr_data[d], SEED ^ {13'b0, ea[beat]});
         chk("beat_last", wr_last[d], (beat == n - 1));
         chk("beat_busy", busy[d], 1'b1);
         chk("beat_no_done", done[d], 1'b0);
         rdy = pat[pc % 4];
         pc++;
         wr_ready[d] = rdy;
         pulsed = 1'b0;
         if (beat == inj && rdy) begin
            req_addr[d]  = 19'h100;
            req_valid[d] = 1'b1;
            pulsed       = 1'b1;
         end
         step();
         if (pulsed) req_valid[d] = 1'b0;
         if (rdy) beat++;
      end
      chk("beat_count", beat, n);
      wr_ready[d] = 1'b0;
      chk("done_pulse", done[d], 1'b1);
      chk("done_valid_low", wr_valid[d], 1'b0);
      chk("done_last_low", wr_last[d], 1'b0);
      chk("done_busy", busy[d], 1'b1);
      chk("done_req_ready", req_ready[d], 1'b0);
   endtask

   // Cycle after DONE: back in IDLE.
   task automatic post_done(input int d);
      step();
      chk("idle_done_low", done[d], 1'b0);
      chk("idle_busy_low", busy[d], 1'b0);
      chk("idle_req_ready", req_ready[d], 1'b1);
      chk("idle_valid_low", wr_valid[d], 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst_n     = 1'b0;
      req_valid = '0;
      wr_ready  = '0;
      for (int i = 0; i < 3; i++) req_addr[i] = '0;
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("rst_req_ready", req_ready[i], 1'b1);
         chk("rst_busy", busy[i], 1'b0);
         chk("rst_valid", wr_valid[i], 1'b0);
         chk("rst_done", done[i], 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Basic incrementing burst; wr_ready high during WAIT must not advance idx.
      wr_ready[0] = 1'b1;
      accept(0, 19'h10);
      stream(0, 2, 8, ea_basic, 4'b1111, -1);
      post_done(0);

      // Wrapping burst.
      accept(1, 19'h1D);
      stream(1, 2, 8, ea_wrap, 4'b1111, -1);
      post_done(1);

      // Address rollover with zero latency.
      accept(2, 19'h7FFFE);
      stream(2, 0, 4, ea_roll, 4'b1111, -1);
      post_done(2);

      // Backpressure pattern 1,0,0,1 repeating.
      accept(0, 19'h10);
      stream(0, 2, 8, ea_basic, 4'b1001, -1);
      post_done(0);

      // Request pulse mid-burst is ignored; then a held request is accepted
      // in the first IDLE cycle after DONE.
      accept(0, 19'h40);
      stream(0, 2, 8, ea_40, 4'b1111, 3);
      req_addr[0]  = 19'h60;
      req_valid[0] = 1'b1;
      step();
      chk("held_idle_ready", req_ready[0], 1'b1);
      chk("held_idle_busy", busy[0], 1'b0);
      step();
      chk("held_accepted_ready", req_ready[0], 1'b0);
      chk("held_accepted_busy", busy[0], 1'b1);
      req_valid[0] = 1'b0;
      stream(0, 2, 8, ea_60, 4'b1111, -1);
      post_done(0);

      // Asynchronous reset after the 3rd beat.
      accept(0, 19'h30);
      wr_ready[0] = 1'b1;
      cyc = 0;
      while (!wr_valid[0] && cyc < 50) begin
         step();
         cyc++;
      end
      chk("rst_mid_valid", wr_valid[0], 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_addr", wr_addr[0], 19'h33);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_valid", wr_valid[0], 1'b0);
      chk("async_done", done[0], 1'b0);
      chk("async_busy", busy[0], 1'b0);
      chk("async_last", wr_last[0], 1'b0);
      chk("async_req_ready", req_ready[0], 1'b1);
      wr_ready[0] = 1'b0;
      #13;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("after_rst_idle", req_ready[0], 1'b1);
      accept(0, 19'h30);
      stream(0, 2, 8, ea_30, 4'b1111, -1);
      post_done(0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
